// File: rtl/pulse_pair_pkg.sv
// pulse_pair_pkg: shared types and default widths for the pulse_pair_gen slice.
// Holds the FSM state enum and the latched burst configuration record.
package pulse_pair_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_BURST_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pp_state_t;

    // Configuration captured when a start is accepted. Fields use the default
    // widths; builds that override CNT_W/BURST_W must not exceed them.
    typedef struct packed {
        logic [DEF_CNT_W-1:0]   period;
        logic [DEF_CNT_W-1:0]   d_offset;
        logic [DEF_CNT_W-1:0]   d_width;
        logic [DEF_CNT_W-1:0]   f_offset;
        logic [DEF_CNT_W-1:0]   f_width;
        logic [DEF_BURST_W-1:0] burst;
    } pp_cfg_t;

endpackage

// File: rtl/pulse_pair_gen_window.sv
// pulse_window: decides whether a timebase value lies inside one pulse window.
// The end of the window is formed one bit wider than the counter, so a large
// offset plus width can never wrap back into the period. Anything at or past
// the period is clipped, which also makes offset >= period a constant 0.
module pulse_window
    import pulse_pair_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic [CNT_W-1:0] next_cnt,
    input  logic [CNT_W-1:0] offset,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    output logic             win
);

    logic [CNT_W:0] win_end;

    assign win_end = {1'b0, offset} + {1'b0, width};

    assign win = (next_cnt >= offset)
              && ({1'b0, next_cnt} < win_end)
              && (next_cnt < period);

endmodule

// File: rtl/pulse_pair_gen.sv
// pulse_pair_gen: register-configured burst of periodic pulses on d_out/f_out.
// A burst is `burst` periods of `period` cycles; each output is high while the
// timebase sits inside its own offset/width window. All outputs are registers
// whose next value is derived from the next timebase value, so outputs line up
// with the timebase with no extra latency.
// Optional feature: define PULSE_PAIR_OVL_CNT_EN to count RUN cycles where both
// outputs are high on ovl_cnt; without it ovl_cnt is tied to 0.
module pulse_pair_gen
    import pulse_pair_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [CNT_W-1:0]         period,
    input  logic [CNT_W-1:0]         d_offset,
    input  logic [CNT_W-1:0]         d_width,
    input  logic [CNT_W-1:0]         f_offset,
    input  logic [CNT_W-1:0]         f_width,
    input  logic [BURST_W-1:0]       burst,
    output logic                     d_out,
    output logic                     f_out,
    output logic                     busy,
    output logic                     done,
    output logic [BURST_W-1:0]       pulse_idx,
    output logic [CNT_W+BURST_W-1:0] ovl_cnt
);

    pp_state_t          state_q;
    pp_state_t          state_n;
    pp_cfg_t            cfg_q;
    pp_cfg_t            cfg_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_n;
    logic [BURST_W-1:0] idx_n;
    logic               busy_n;
    logic               done_n;
    logic               accept;
    logic               d_win;
    logic               f_win;
    logic               d_n;
    logic               f_n;

    logic [CNT_W-1:0]   cur_period;
    logic [CNT_W-1:0]   cur_d_offset;
    logic [CNT_W-1:0]   cur_d_width;
    logic [CNT_W-1:0]   cur_f_offset;
    logic [CNT_W-1:0]   cur_f_width;
    logic [BURST_W-1:0] cur_burst;

    logic [CNT_W-1:0]   win_period;
    logic [CNT_W-1:0]   win_d_offset;
    logic [CNT_W-1:0]   win_d_width;
    logic [CNT_W-1:0]   win_f_offset;
    logic [CNT_W-1:0]   win_f_width;

    // A start only counts from IDLE, with a usable config and no competing stop.
    assign accept = (state_q == IDLE) && start && !stop
                 && (period != '0) && (burst != '0);

    assign cur_period   = CNT_W'(cfg_q.period);
    assign cur_d_offset = CNT_W'(cfg_q.d_offset);
    assign cur_d_width  = CNT_W'(cfg_q.d_width);
    assign cur_f_offset = CNT_W'(cfg_q.f_offset);
    assign cur_f_width  = CNT_W'(cfg_q.f_width);
    assign cur_burst    = BURST_W'(cfg_q.burst);

    // On the accepting edge the config is not latched yet, so the first window
    // is evaluated straight from the inputs; afterwards from the latched copy.
    assign win_period   = accept ? period   : cur_period;
    assign win_d_offset = accept ? d_offset : cur_d_offset;
    assign win_d_width  = accept ? d_width  : cur_d_width;
    assign win_f_offset = accept ? f_offset : cur_f_offset;
    assign win_f_width  = accept ? f_width  : cur_f_width;

    pulse_window #(.CNT_W(CNT_W)) u_d_window (
        .next_cnt (cnt_n),
        .offset   (win_d_offset),
        .width    (win_d_width),
        .period   (win_period),
        .win      (d_win)
    );

    pulse_window #(.CNT_W(CNT_W)) u_f_window (
        .next_cnt (cnt_n),
        .offset   (win_f_offset),
        .width    (win_f_width),
        .period   (win_period),
        .win      (f_win)
    );

    // Outputs can only be high in a cycle that will be spent in RUN.
    assign d_n = (state_n == RUN) && d_win;
    assign f_n = (state_n == RUN) && f_win;

    // Next state, timebase, period index, status flags and config capture.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = pulse_idx;
        busy_n  = busy;
        done_n  = 1'b0;
        cfg_n   = cfg_q;
        case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                if (accept) begin
                    state_n        = RUN;
                    cnt_n          = '0;
                    idx_n          = '0;
                    busy_n         = 1'b1;
                    cfg_n.period   = DEF_CNT_W'(period);
                    cfg_n.d_offset = DEF_CNT_W'(d_offset);
                    cfg_n.d_width  = DEF_CNT_W'(d_width);
                    cfg_n.f_offset = DEF_CNT_W'(f_offset);
                    cfg_n.f_width  = DEF_CNT_W'(f_width);
                    cfg_n.burst    = DEF_BURST_W'(burst);
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                end else if (cnt_q == cur_period - CNT_W'(1)) begin
                    cnt_n = '0;
                    if (pulse_idx == cur_burst - BURST_W'(1)) begin
                        state_n = DONE;
                        idx_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = pulse_idx + BURST_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State register plus every registered output; reset may hit mid-burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            cnt_q     <= '0;
            pulse_idx <= '0;
            d_out     <= 1'b0;
            f_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cfg_q     <= cfg_n;
            cnt_q     <= cnt_n;
            pulse_idx <= idx_n;
            d_out     <= d_n;
            f_out     <= f_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

`ifdef PULSE_PAIR_OVL_CNT_EN
    logic [CNT_W+BURST_W-1:0] ovl_q;

    // Overlap counter: restarts on accepted start, saturates, holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_q <= '0;
        end else if (accept) begin
            ovl_q <= '0;
        end else if ((state_q == RUN) && d_out && f_out && (ovl_q != '1)) begin
            ovl_q <= ovl_q + 1'b1;
        end
    end

    assign ovl_cnt = ovl_q;
`else
    assign ovl_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_pair_gen.sv
// tb_pulse_pair_gen: table-driven and randomized checks of pulse_pair_gen.
// Expected outputs come from a cycle-index model: RUN cycle k sits at
// cnt = k % period in period k / period, and each output is high when cnt
// falls in [offset, offset + width) using plain integer arithmetic.
module tb_pulse_pair_gen;

    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     stop;
    logic [CNT_W-1:0]         period;
    logic [CNT_W-1:0]         d_offset;
    logic [CNT_W-1:0]         d_width;
    logic [CNT_W-1:0]         f_offset;
    logic [CNT_W-1:0]         f_width;
    logic [BURST_W-1:0]       burst;
    logic                     d_out;
    logic                     f_out;
    logic                     busy;
    logic                     done;
    logic [BURST_W-1:0]       pulse_idx;
    logic [CNT_W+BURST_W-1:0] ovl_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int period;
        int d_off;
        int d_w;
        int f_off;
        int f_w;
        int burst;
        int exp_d_hi;
        int exp_f_hi;
        int exp_ovl;
    } vec_t;

    vec_t tbl[6];

    pulse_pair_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .d_offset  (d_offset),
        .d_width   (d_width),
        .f_offset  (f_offset),
        .f_width   (f_width),
        .burst     (burst),
        .d_out     (d_out),
        .f_out     (f_out),
        .busy      (busy),
        .done      (done),
        .pulse_idx (pulse_idx),
        .ovl_cnt   (ovl_cnt)
    );

    always #5 clk = ~clk;

    function automatic int ovlExpect(input int model);
`ifdef PULSE_PAIR_OVL_CNT_EN
        return model;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic scrambleCfg();
        period   = CNT_W'($urandom);
        d_offset = CNT_W'($urandom);
        d_width  = CNT_W'($urandom);
        f_offset = CNT_W'($urandom);
        f_width  = CNT_W'($urandom);
        burst    = BURST_W'($urandom);
    endtask

    // Called just after a falling edge; returns at the falling edge of RUN cycle 0.
    task automatic applyStimulus(input vec_t v);
        period   = CNT_W'(v.period);
        d_offset = CNT_W'(v.d_off);
        d_width  = CNT_W'(v.d_w);
        f_offset = CNT_W'(v.f_off);
        f_width  = CNT_W'(v.f_w);
        burst    = BURST_W'(v.burst);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_d"}, 64'(d_out), 64'd0);
        checkOutput({tag, "_f"}, 64'(f_out), 64'd0);
    endtask

    // Runs one burst, checking every RUN cycle against the model. Returns the
    // observed high counts and the ovl_cnt value seen after the burst.
    task automatic runBurst(input vec_t v, input int stop_k, input int restart_k,
                            input bit start_in_done, output int d_hi,
                            output int f_hi, output int ovl_seen);
        int total;
        int model_ov;
        bit stopped;
        total    = v.period * v.burst;
        model_ov = 0;
        stopped  = 1'b0;
        d_hi     = 0;
        f_hi     = 0;
        ovl_seen = 0;
        applyStimulus(v);
        for (int k = 0; k < total; k++) begin
            int c;
            int idx;
            bit ed;
            bit ef;
            c   = k % v.period;
            idx = k / v.period;
            ed  = (c >= v.d_off) && (c < v.d_off + v.d_w);
            ef  = (c >= v.f_off) && (c < v.f_off + v.f_w);
            checkOutput("run_d", 64'(d_out), 64'(ed));
            checkOutput("run_f", 64'(f_out), 64'(ef));
            checkOutput("run_busy", 64'(busy), 64'd1);
            checkOutput("run_done", 64'(done), 64'd0);
            checkOutput("run_idx", 64'(pulse_idx), 64'(idx));
            d_hi += int'(d_out);
            f_hi += int'(f_out);
            if (ed && ef) model_ov++;
            scrambleCfg();
            start = (k == restart_k);
            stop  = (k == stop_k);
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            if (k == stop_k) begin
                stopped = 1'b1;
                checkIdle("stop");
                checkOutput("stop_idx", 64'(pulse_idx), 64'd0);
                checkOutput("stop_ovl", 64'(ovl_cnt), 64'(ovlExpect(model_ov)));
                ovl_seen = int'(ovl_cnt);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    checkIdle("after_stop");
                end
                break;
            end
        end
        if (!stopped) begin
            checkOutput("done_pulse", 64'(done), 64'd1);
            checkOutput("done_busy", 64'(busy), 64'd0);
            checkOutput("done_d", 64'(d_out), 64'd0);
            checkOutput("done_f", 64'(f_out), 64'd0);
            checkOutput("done_ovl", 64'(ovl_cnt), 64'(ovlExpect(model_ov)));
            ovl_seen = int'(ovl_cnt);
            if (start_in_done) begin
                period = 16'd4;
                burst  = 8'd2;
                start  = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            checkIdle("post_done");
            checkOutput("post_done_ovl", 64'(ovl_cnt), 64'(ovlExpect(model_ov)));
        end
    endtask

    initial begin
        int d_hi;
        int f_hi;
        int ovl_seen;
        vec_t v;

        tbl[0] = '{672, 0, 6, 4, 4, 4, 24, 16, 8};
        tbl[1] = '{10, 8, 5, 0, 0, 2, 4, 0, 0};
        tbl[2] = '{5, 0, 5, 2, 10, 3, 15, 9, 9};
        tbl[3] = '{1, 0, 1, 1, 1, 3, 3, 0, 0};
        tbl[4] = '{8, 3, 2, 7, 65535, 2, 4, 2, 0};
        tbl[5] = '{6, 65535, 4, 0, 6, 1, 0, 6, 0};

        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        scrambleCfg();
        #12;
        checkIdle("reset");
        checkOutput("reset_idx", 64'(pulse_idx), 64'd0);
        checkOutput("reset_ovl", 64'(ovl_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table: burst shapes, clipping, zero width, huge offsets/widths.
        // Entry 0 also gets a start mid-burst, entry 1 a start during DONE.
        for (int i = 0; i < 6; i++) begin
            runBurst(tbl[i], -1, (i == 0) ? 100 : -1, (i == 1), d_hi, f_hi, ovl_seen);
            checkOutput($sformatf("tbl%0d_d_hi", i), 64'(d_hi), 64'(tbl[i].exp_d_hi));
            checkOutput($sformatf("tbl%0d_f_hi", i), 64'(f_hi), 64'(tbl[i].exp_f_hi));
            checkOutput($sformatf("tbl%0d_ovl", i), 64'(ovl_seen), 64'(ovlExpect(tbl[i].exp_ovl)));
        end

        // Illegal starts: zero period, zero burst, and start together with stop.
        for (int i = 0; i < 3; i++) begin
            period = (i == 0) ? 16'd0 : 16'd5;
            burst  = (i == 1) ? 8'd0 : 8'd3;
            stop   = (i == 2);
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            for (int j = 0; j < 4; j++) begin
                checkIdle($sformatf("illegal%0d", i));
                @(negedge clk);
            end
        end

        // Stop at cnt 15 of the first period, then an immediate fresh burst.
        v = '{20, 10, 8, 14, 3, 3, 0, 0, 0};
        runBurst(v, 15, -1, 1'b0, d_hi, f_hi, ovl_seen);
        runBurst(tbl[2], -1, -1, 1'b0, d_hi, f_hi, ovl_seen);
        checkOutput("restart_d_hi", 64'(d_hi), 64'(tbl[2].exp_d_hi));

        // Asynchronous reset mid-burst, not aligned to any clock edge.
        v = '{50, 0, 40, 0, 40, 2, 0, 0, 0};
        applyStimulus(v);
        repeat (9) @(negedge clk);
        checkOutput("pre_rst_d", 64'(d_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkIdle("async_rst");
        checkOutput("async_rst_idx", 64'(pulse_idx), 64'd0);
        checkOutput("async_rst_ovl", 64'(ovl_cnt), 64'd0);
        #4 rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checkIdle("post_rst");
        end

        // Randomized bursts against the model, with occasional mid-burst starts.
        for (int r = 0; r < 10; r++) begin
            v.period = int'($urandom_range(1, 12));
            v.d_off  = int'($urandom_range(0, 14));
            v.d_w    = int'($urandom_range(0, 14));
            v.f_off  = int'($urandom_range(0, 14));
            v.f_w    = int'($urandom_range(0, 14));
            v.burst  = int'($urandom_range(1, 4));
            runBurst(v, -1, (r % 3 == 0) ? int'($urandom_range(0, 5)) : -1,
                     1'b0, d_hi, f_hi, ovl_seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
